// File: rtl/lpm_shift_tx_pkg.sv
// Shared types and helpers for the lpm_shift_tx parallel-in/serial-out transmitter.
// Holds the FSM state encoding, the direction constants and the counter-width function.
package lpm_shift_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [23:0] DIR_LSB = "LSB";
    localparam logic [23:0] DIR_MSB = "MSB";

    // Counter width for an index in [0, n-1]; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lpm_bit_counter.sv
// Modulo-WIDTH up-counter tracking which bit of the word is on the serial line.
// Registered count, last flag is combinational; clear wins over inc, no backpressure.
module lpm_bit_counter
    import lpm_shift_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lpm_shift_tx.sv
// Parallel-in serial-out transmitter: first bit one edge after accept, lpm_width cycles per word.
// ready/load handshake; enable=0 freezes shifting and drops ready, zero-gap reload on the last bit.
module lpm_shift_tx
    import lpm_shift_tx_pkg::*;
#(
    parameter int   lpm_width     = 8,
    parameter       lpm_direction = "LSB",
    parameter logic lpm_idle      = 1'b1
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 sclr,
    input  logic [lpm_width-1:0] data,
    input  logic                 load,
    output logic                 ready,
    input  logic                 enable,
    output logic                 shiftout,
    output logic                 busy,
    output logic                 done
);

    if (lpm_direction != DIR_LSB && lpm_direction != DIR_MSB) begin : g_bad_dir
        $error("lpm_shift_tx: unsupported lpm_direction, behaving as LSB");
    end

    localparam bit MSB_FIRST = (lpm_direction == DIR_MSB);

    // The bit that sits at the output end of a word, given the send order.
    function automatic logic out_bit(input logic [lpm_width-1:0] v);
        return MSB_FIRST ? v[lpm_width-1] : v[0];
    endfunction

    state_e               state_q, state_d;
    logic [lpm_width-1:0] shreg_q, shreg_d;
    logic                 shiftout_q, shiftout_d;
    logic                 done_q, done_d;
    logic [lpm_width-1:0] shreg_adv;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 cnt_last;

    lpm_bit_counter #(
        .WIDTH (lpm_width)
    ) u_cnt (
        .clk_i   (clock),
        .rst_ni  (aclr_n),
        .clear_i (cnt_clr),
        .inc_i   (cnt_inc),
        .last_o  (cnt_last)
    );

    assign shreg_adv = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    assign ready     = (state_q == IDLE) | ((state_q == SHIFT) & cnt_last & enable);
    assign busy      = (state_q == SHIFT);
    assign shiftout  = shiftout_q;
    assign done      = done_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        shiftout_d = shiftout_q;
        done_d     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (sclr) begin
            state_d    = IDLE;
            shiftout_d = lpm_idle;
            cnt_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    shiftout_d = lpm_idle;
                    if (load) begin
                        shreg_d    = data;
                        shiftout_d = out_bit(data);
                        cnt_clr    = 1'b1;
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            done_d = 1'b1;
                            // Reload here keeps the stream gap-free between words.
                            if (load) begin
                                shreg_d    = data;
                                shiftout_d = out_bit(data);
                                cnt_clr    = 1'b1;
                            end else begin
                                state_d    = IDLE;
                                shiftout_d = lpm_idle;
                            end
                        end else begin
                            shreg_d    = shreg_adv;
                            shiftout_d = out_bit(shreg_adv);
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    shiftout_d = lpm_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            shiftout_q <= lpm_idle;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            shiftout_q <= shiftout_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_lpm_shift_tx.sv
// Scoreboard bench for lpm_shift_tx: three instances (LSB/8, MSB/8, LSB/1 with idle 0)
// driven by directed then random stimulus; expected bit streams come from the word itself.
module tb_lpm_shift_tx;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int fin_cnt = 0;

    task automatic chk(input string nm, input int g, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %b, required %b (t=%0t)", nm, g, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int          W   = (g == 2) ? 1 : 8;
        localparam logic [23:0] DIR = (g == 1) ? "MSB" : "LSB";
        localparam logic        IDL = (g == 2) ? 1'b0 : 1'b1;

        logic         aclr_n;
        logic         sclr;
        logic         load;
        logic         enable;
        logic         ready;
        logic         shiftout;
        logic         busy;
        logic         done;
        logic [W-1:0] data;

        exp_t         exp_q[$];
        int           rem   = 0;
        logic         p_acc = 1'b0;
        logic         p_clr = 1'b0;
        logic         p_en  = 1'b0;
        logic [W-1:0] p_dat = '0;

        lpm_shift_tx #(
            .lpm_width     (W),
            .lpm_direction (DIR),
            .lpm_idle      (IDL)
        ) dut (
            .clock    (clk),
            .aclr_n   (aclr_n),
            .sclr     (sclr),
            .data     (data),
            .load     (load),
            .ready    (ready),
            .enable   (enable),
            .shiftout (shiftout),
            .busy     (busy),
            .done     (done)
        );

        // One clock of stimulus: account for the edge just taken, then drive the next inputs.
        task automatic step(input logic ld, input logic [7:0] dt, input logic en,
                            input logic sc, input logic rn);
            logic rdy_m;
            exp_t e;
            int   idx;
            @(posedge clk);
            #1;
            if (p_clr) begin
                rem = 0;
                exp_q.delete();
            end else if (p_acc) begin
                rem = W;
                for (int i = 0; i < W; i++) begin
                    idx    = (DIR == "MSB") ? (W - 1 - i) : i;
                    e.b    = p_dat[idx];
                    e.last = (i == W - 1);
                    exp_q.push_back(e);
                end
            end else if (p_en && rem > 0) begin
                rem--;
            end
            aclr_n = rn;
            sclr   = sc;
            load   = ld;
            enable = en;
            data   = dt[W-1:0];
            rdy_m  = (rem == 0) || (rem == 1 && en);
            p_acc  = rn && !sc && ld && rdy_m;
            p_clr  = sc || !rn;
            p_en   = en;
            p_dat  = dt[W-1:0];
            if (!rn) begin
                rem = 0;
                exp_q.delete();
            end
        endtask

        initial begin
            aclr_n = 1'b0;
            sclr   = 1'b0;
            load   = 1'b0;
            enable = 1'b1;
            data   = '0;
            step(0, 8'h00, 1, 0, 0);
            repeat (3) step(0, 8'h00, 1, 0, 1);
            // single word
            step(1, 8'hA5, 1, 0, 1);
            repeat (W + 3) step(0, 8'h00, 1, 0, 1);
            // stall on bit 2
            step(1, 8'h81, 1, 0, 1);
            repeat (2) step(0, 8'h00, 1, 0, 1);
            repeat (3) step(0, 8'h00, 0, 0, 1);
            repeat (W + 4) step(0, 8'h00, 1, 0, 1);
            // back-to-back FF then 00
            step(1, 8'hFF, 1, 0, 1);
            repeat (W) step(1, 8'h00, 1, 0, 1);
            repeat (W + 3) step(0, 8'h00, 1, 0, 1);
            // async reset mid-word, then a clean word
            step(1, 8'h3C, 1, 0, 1);
            repeat (3) step(0, 8'h00, 1, 0, 1);
            repeat (2) step(0, 8'h00, 1, 0, 0);
            step(1, 8'h3C, 1, 0, 1);
            repeat (W + 3) step(0, 8'h00, 1, 0, 1);
            // sclr beats load in IDLE, then a one-bit-pattern word
            step(1, 8'h5A, 1, 1, 1);
            repeat (3) step(0, 8'h00, 1, 0, 1);
            step(1, 8'h01, 1, 0, 1);
            repeat (W + 3) step(0, 8'h00, 1, 0, 1);
            repeat (1500) begin
                step(($urandom % 3) == 0, 8'($urandom), ($urandom % 5) != 0,
                     ($urandom % 60) == 0, ($urandom % 150) != 0);
            end
            repeat (W + 3) step(0, 8'h00, 1, 0, 1);
            fin_cnt++;
        end

        initial begin
            logic dexp;
            dexp = 1'b0;
            forever begin
                @(negedge clk);
                if (!aclr_n) begin
                    chk("rst_shiftout", g, shiftout, IDL);
                    chk("rst_busy", g, busy, 1'b0);
                    chk("rst_done", g, done, 1'b0);
                    chk("rst_ready", g, ready, 1'b1);
                    dexp = 1'b0;
                end else begin
                    chk("done", g, done, dexp);
                    dexp = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("idle_shiftout", g, shiftout, IDL);
                        chk("idle_busy", g, busy, 1'b0);
                        chk("idle_ready", g, ready, 1'b1);
                    end else begin
                        chk("shiftout", g, shiftout, exp_q[0].b);
                        chk("busy", g, busy, 1'b1);
                        chk("ready", g, ready, exp_q[0].last && enable);
                        if (enable && !sclr) begin
                            dexp = exp_q[0].last;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (fin_cnt < 3 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("drivers_finished", 0, logic'(fin_cnt >= 3), 1'b1);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
